// File: rtl/life_rule.sv
// rtl/life_rule.sv - serial B3/S23 rule engine and generation sequencer for life_data
// Builds a 3x3 window from the old-generation stream and gates writeback per generation.
module life_rule #(
   parameter int X     = 8,
   parameter int Y     = 8,
   parameter int LOG2X = 3,
   parameter int LOG2Y = 3,
   parameter int GENW  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cell_in,
   input  logic            run_key,
   input  logic            step_key,
   output logic            pipe_out,
   output logic            nxt_bit,
   output logic [GENW-1:0] gen_count
);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t           state;
   state_t           next_state;
   logic [2*X+2:0]   w;
   logic [LOG2X-1:0] ccol;
   logic [LOG2Y-1:0] crow;
   logic             step_d;
   logic             step_evt;
   logic             centre_zero;
   logic             col_first, col_last, row_first, row_last;
   logic             t_r, t_l, t_dr, t_d, t_dl, t_ur, t_u, t_ul;
   logic [3:0]       n;
   logic             next_cell;

   assign col_first   = (ccol == '0);
   assign col_last    = (ccol == LOG2X'(X-1));
   assign row_first   = (crow == '0);
   assign row_last    = (crow == LOG2Y'(Y-1));
   assign centre_zero = col_first && row_first;
   assign step_evt    = step_key & ~step_d;

   // Centre sits at w[X+1]; taps that would fall off the board edge are forced dead.
   assign t_r  = w[X]     & ~col_last;
   assign t_l  = w[X+2]   & ~col_first;
   assign t_dr = w[0]     & ~col_last  & ~row_last;
   assign t_d  = w[1]     & ~row_last;
   assign t_dl = w[2]     & ~col_first & ~row_last;
   assign t_ur = w[2*X]   & ~col_last  & ~row_first;
   assign t_u  = w[2*X+1] & ~row_first;
   assign t_ul = w[2*X+2] & ~col_first & ~row_first;

   assign n = 4'(t_r) + 4'(t_l) + 4'(t_dr) + 4'(t_d) + 4'(t_dl)
            + 4'(t_ur) + 4'(t_u) + 4'(t_ul);
   assign next_cell = (n == 4'd3) | (w[X+1] & (n == 4'd2));

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (run_key || step_evt) next_state = ARM;
         ARM:     if (centre_zero) next_state = RUN;
         RUN:     if (centre_zero && !run_key) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w         <= '0;
         ccol      <= LOG2X'(X-2);
         crow      <= LOG2Y'(Y-2);
         step_d    <= 1'b0;
         state     <= IDLE;
         nxt_bit   <= 1'b0;
         pipe_out  <= 1'b0;
         gen_count <= '0;
      end else begin
         w        <= {w[2*X+1:0], cell_in};
         step_d   <= step_key;
         pipe_out <= next_cell;
         state    <= next_state;
         nxt_bit  <= (next_state == RUN);
         if (col_last) begin
            ccol <= '0;
            crow <= row_last ? '0 : crow + LOG2Y'(1);
         end else begin
            ccol <= ccol + LOG2X'(1);
         end
         // A generation closes when the centre wraps back to cell 0 while running.
         if (state == RUN && centre_zero)
            gen_count <= gen_count + GENW'(1);
      end
   end

endmodule

// File: tb/tb_life_rule.sv
// tb/tb_life_rule.sv - self-checking bench for life_rule on an 8x8 board
// Reference model evaluates B3/S23 on a 2D board; results are queued and matched against pipe_out.
module tb_life_rule;

   localparam int X = 8;
   localparam int Y = 8;
   localparam int N = X * Y;

   logic        clk = 1'b0;
   logic        reset;
   logic        cell_in;
   logic        run_key;
   logic        step_key;
   logic        pipe_out;
   logic        nxt_bit;
   logic [15:0] gen_count;

   int   total = 0;
   int   bad   = 0;
   logic exp_q[$];

   life_rule #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(3), .GENW(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .cell_in   (cell_in),
      .run_key   (run_key),
      .step_key  (step_key),
      .pipe_out  (pipe_out),
      .nxt_bit   (nxt_bit),
      .gen_count (gen_count)
   );

   always #5 clk = ~clk;

   function automatic logic life_ref(input logic [N-1:0] b, input int idx);
      int r, c, rr, cc, cnt;
      r = idx / X;
      c = idx % X;
      cnt = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < Y && cc >= 0 && cc < X)
               cnt += int'(b[rr*X+cc]);
         end
      return (cnt == 3) || (b[idx] && cnt == 2);
   endfunction

   // Leaves the bench 1 time unit into cycle t=0 (first cycle after release).
   task automatic do_reset();
      reset    = 1'b1;
      cell_in  = 1'b0;
      run_key  = 1'b0;
      step_key = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (pipe_out !== 1'b0) begin bad++; $display("FAIL reset_pipe_out got=%b want=0", pipe_out); end
      total++; if (nxt_bit !== 1'b0) begin bad++; $display("FAIL reset_nxt_bit got=%b want=0", nxt_bit); end
      total++; if (gen_count !== 16'd0) begin bad++; $display("FAIL reset_gen_count got=%0d want=0", gen_count); end
      for (int t = 0; t < 100; t++) begin
         total++;
         if (nxt_bit !== 1'b0) begin bad++; $display("FAIL idle_nxt_bit t=%0d got=%b want=0", t, nxt_bit); end
         @(posedge clk); #1;
      end
   endtask

   // Assumes cycle t=0 after reset; step rises at t=5.
   task automatic test_step_alignment(input string tag);
      logic [N-1:0] b;
      logic         e;
      b = {$urandom, $urandom};
      exp_q.delete();
      for (int t = 0; t < 150; t++) begin
         if (t >= 11 && t <= 74) begin
            e = exp_q.pop_front();
            total++;
            if (pipe_out !== e) begin bad++; $display("FAIL %s_pipe_out t=%0d got=%b want=%b", tag, t, pipe_out, e); end
         end
         total++;
         if (nxt_bit !== (t >= 11 && t <= 74)) begin
            bad++; $display("FAIL %s_nxt_bit t=%0d got=%b want=%b", tag, t, nxt_bit, (t >= 11 && t <= 74));
         end
         total++;
         if (gen_count !== ((t >= 75) ? 16'd1 : 16'd0)) begin
            bad++; $display("FAIL %s_gen_count t=%0d got=%0d want=%0d", tag, t, gen_count, (t >= 75) ? 1 : 0);
         end
         cell_in  = (t < N) ? b[t] : 1'b0;
         if (t < N) exp_q.push_back(life_ref(b, t));
         step_key = (t >= 5 && t <= 7);
         run_key  = 1'b0;
         @(posedge clk); #1;
      end
      step_key = 1'b0;
   endtask

   task automatic test_blinker();
      logic [N-1:0] b;
      logic         e;
      int           ones;
      do_reset();
      b = '0;
      b[26] = 1'b1; b[27] = 1'b1; b[28] = 1'b1;
      ones = 0;
      for (int t = 0; t <= 74; t++) begin
         if (t >= 11) begin
            e = exp_q.pop_front();
            total++;
            if (pipe_out !== e) begin bad++; $display("FAIL blinker_model t=%0d got=%b want=%b", t, pipe_out, e); end
            total++;
            if (pipe_out !== (t == 30 || t == 38 || t == 46)) begin
               bad++; $display("FAIL blinker_pos t=%0d got=%b want=%b", t, pipe_out, (t == 30 || t == 38 || t == 46));
            end
            if (pipe_out === 1'b1) ones++;
         end
         cell_in = (t >= 26 && t <= 28);
         if (t < N) exp_q.push_back(life_ref(b, t));
         @(posedge clk); #1;
      end
      cell_in = 1'b0;
      total++;
      if (ones != 3) begin bad++; $display("FAIL blinker_count got=%0d want=3", ones); end
   endtask

   task automatic test_borders();
      logic [N-1:0] b;
      logic         e;
      do_reset();
      b = '1;
      for (int t = 0; t <= 74; t++) begin
         if (t >= 11) begin
            e = exp_q.pop_front();
            total++;
            if (pipe_out !== e) begin bad++; $display("FAIL borders_model t=%0d got=%b want=%b", t, pipe_out, e); end
            total++;
            if (pipe_out !== (t == 11 || t == 18 || t == 67 || t == 74)) begin
               bad++; $display("FAIL borders_pos t=%0d got=%b want=%b", t, pipe_out, (t == 11 || t == 18 || t == 67 || t == 74));
            end
         end
         cell_in = (t < N);
         if (t < N) exp_q.push_back(life_ref(b, t));
         @(posedge clk); #1;
      end
      cell_in = 1'b0;
   endtask

   // Board fed periodically as the rotating ring would; generations run back to back.
   task automatic test_back_to_back();
      logic [N-1:0] b;
      logic         e;
      logic         want_nb;
      int           g;
      do_reset();
      b = {$urandom, $urandom};
      for (int t = 0; t < 420; t++) begin
         if (t >= 11) begin
            e = exp_q.pop_front();
            total++;
            if (pipe_out !== e) begin bad++; $display("FAIL b2b_pipe_out t=%0d got=%b want=%b", t, pipe_out, e); end
         end
         want_nb = (t >= 11 && t <= 330);
         total++;
         if (nxt_bit !== want_nb) begin bad++; $display("FAIL b2b_nxt_bit t=%0d got=%b want=%b", t, nxt_bit, want_nb); end
         g = int'(t >= 75) + int'(t >= 139) + int'(t >= 203) + int'(t >= 267) + int'(t >= 331);
         total++;
         if (gen_count !== 16'(g)) begin bad++; $display("FAIL b2b_gen_count t=%0d got=%0d want=%0d", t, gen_count, g); end
         cell_in = b[t % N];
         exp_q.push_back(life_ref(b, t % N));
         run_key = (t >= 3 && t <= 300);
         @(posedge clk); #1;
      end
      run_key = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_ignored_step();
      do_reset();
      for (int t = 0; t < 150; t++) begin
         total++;
         if (nxt_bit !== (t >= 11 && t <= 74)) begin
            bad++; $display("FAIL ign_nxt_bit t=%0d got=%b want=%b", t, nxt_bit, (t >= 11 && t <= 74));
         end
         step_key = (t >= 5 && t <= 7) || (t >= 40 && t <= 41);
         cell_in  = 1'b0;
         @(posedge clk); #1;
      end
      step_key = 1'b0;
      total++;
      if (gen_count !== 16'd1) begin bad++; $display("FAIL ign_gen_count got=%0d want=1", gen_count); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      for (int t = 0; t <= 50; t++) begin
         cell_in  = 1'b1;
         step_key = (t >= 5 && t <= 7);
         if (t == 50) begin
            total++;
            if (nxt_bit !== 1'b1) begin bad++; $display("FAIL mid_pre_nxt_bit got=%b want=1", nxt_bit); end
            reset = 1'b1;
         end
         @(posedge clk); #1;
      end
      total++; if (nxt_bit !== 1'b0) begin bad++; $display("FAIL mid_nxt_bit got=%b want=0", nxt_bit); end
      total++; if (pipe_out !== 1'b0) begin bad++; $display("FAIL mid_pipe_out got=%b want=0", pipe_out); end
      total++; if (gen_count !== 16'd0) begin bad++; $display("FAIL mid_gen_count got=%0d want=0", gen_count); end
      reset    = 1'b0;
      cell_in  = 1'b0;
      step_key = 1'b0;
      test_step_alignment("rerun");
   endtask

   initial begin
      reset    = 1'b1;
      cell_in  = 1'b0;
      run_key  = 1'b0;
      step_key = 1'b0;
      test_reset();
      do_reset();
      test_step_alignment("align");
      test_blinker();
      test_borders();
      test_back_to_back();
      test_ignored_step();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/life_rule.md
# life_rule

- Serial Game-of-Life rule engine and generation sequencer, sitting directly upstream of `life_data`.
- Snoops the old-generation bit stream from the rotating board, builds a 3x3 neighbourhood with a line buffer, and applies B3/S23 with dead (non-toroidal) borders.
- Drives `life_data`'s `pipe_out` with next-generation cell values and its `nxt_bit` with run/step control.

## Interface
Parameters:
- X, 8, board width (>=3)
- Y, 8, board height (>=2)
- LOG2X, 3, width of column counter
- LOG2Y, 3, width of row counter
- GENW, 16, generation counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cell_in  in  1  old-generation cell stream, ascending row-major index; driven from `life_data` data[1]
- run_key  in  1  level; run generations continuously while high
- step_key  in  1  rising edge requests exactly one generation
- pipe_out  out  1  registered next-generation value of the result cell
- nxt_bit  out  1  registered; high exactly while pipe_out carries a generation being written
- gen_count  out  GENW  completed generations, wraps mod 2^GENW

## Operation
- Index tracking: cell_in carries cell 0 in the first cycle after reset is released, then ascending indices wrapping at X*Y-1.
- Centre counters (ccol, crow) track the centre cell. Centre index = cell_in index − (X+2) mod X*Y. Reset values: crow=Y-2, ccol=X-2. Increment every cycle: ccol wraps at X-1 and carries into crow, which wraps at Y-1.
- Window: shift register w[0..2X+2]. Each cycle w[0]<=cell_in and w[k]<=w[k-1]. Reset value is all zeros.
- Centre is w[X+1]. Neighbour taps:
  - w[X] is right; w[X+2] is left.
  - w[0], w[1], w[2] are down-right, down, down-left.
  - w[2X], w[2X+1], w[2X+2] are up-right, up, up-left.
- Border masking, forcing the affected taps to 0:
  - ccol==0 masks w[X+2], w[2], w[2X+2].
  - ccol==X-1 masks w[X], w[0], w[2X].
  - crow==0 masks w[2X..2X+2].
  - crow==Y-1 masks w[0..2].
- Rule: n = sum of 8 masked taps (4 bits, 0..8); next = (n==3) | (w[X+1] & n==2). On each cycle pipe_out<=next.
- Step edge detect: step_d<=step_key each cycle; the event is step_key & !step_d.
- FSM states are IDLE, ARM, RUN; reset state is IDLE.
  - IDLE: if run_key or step event, go to ARM.
  - ARM: on the edge where the centre index is 0 (ccol==0 && crow==0), go to RUN.
  - RUN: on the edge where the centre index is 0 again, gen_count increments; if run_key=1 stay in RUN, else go to IDLE.
- nxt_bit<=(next_state==RUN). It is therefore high for exactly X*Y consecutive cycles per generation, aligned with pipe_out results 0..X*Y-1.
- Step events in ARM or RUN are ignored.
- run_key dropping mid-RUN does not abort the generation; the generation completes.
- run_key dropping in ARM does not cancel the request; the block proceeds to RUN for one generation.
- pipe_out is computed every cycle regardless of state. `life_data` uses it only while nxt_bit=1.

## Timing
- Reset values: pipe_out=0, nxt_bit=0, gen_count=0, FSM=IDLE, window=0, step_d=0, centre counters as above.
- Latency: the result for cell c appears on pipe_out X+3 cycles after c is on cell_in.
- Result index = (cycles since reset release) − (X+3) mod X*Y.
- Writeback lands in the cell's own ring slot. The tap at data[1] is chosen for this: that slot reaches the write position X+4 cycles later.
- IDLE→ARM takes 1 cycle. ARM waits 0..X*Y-1 cycles. Worst-case trigger-to-first-nxt_bit is X*Y+1 cycles.
- Back-to-back generations: nxt_bit stays continuously high with no gap.
- Reset mid-RUN: the next cycle has nxt_bit=0 and gen_count=0. The partially written board is left as is.

## Test plan
All scenarios use X=Y=8; t=0 is the first cycle after reset is released.
- Step alignment: step_key rises at t=5 -> ARM at t=6; nxt_bit high t=11..74; pipe_out at t=11 is cell 0's result; gen_count=1 at t=75; FSM back to IDLE.
- Blinker: cell_in=1 at t=26,27,28 only -> pipe_out=1 exactly at t=30,38,46 (result cells 19,27,35).
- Borders: cell_in=1 for all of t=0..63 -> within t=11..74, pipe_out=1 only at t=11,18,67,74 (corners 0,7,56,63). Any toroidal leak fails this check.
- Continuous run: run_key held from t=3 to t=300 -> nxt_bit rises at t=11 and stays high through the generation ending t=330. gen_count increments at t=75,139,203,267,331 to 5, then the FSM goes to IDLE.
- Ignored step: step_key pulses at t=40 during a RUN started by step -> only one generation is executed (gen_count=1).
- Reset mid-run: reset asserted at t=50 of a RUN -> the next cycle has nxt_bit=0, pipe_out=0, gen_count=0; a subsequent step repeats the alignment scenario exactly.
